sum_sched: RTL and testbench
============================

Name: sum_sched

Overview:
- Round-robin scheduler that shares one sequential summing accumulator among NREQ requesters.
- Each request asks for the sum 1+2+...+n of a requester-supplied n.
- The scheduler grants one requester at a time and sequences the accumulator one addend per clock.
- It returns the SW-bit wrapped result with a one-cycle done pulse to the granted requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NW, 6, width of each requester's n operand.
- SW, 8, accumulator/result width; arithmetic wraps modulo 2^SW.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester; level, sampled only in IDLE.
- n  in  NREQ*NW  operand for requester i on bits [i*NW +: NW].
- gnt  out  NREQ  one-hot grant; held from grant through DONE.
- busy  out  1  high in any state other than IDLE.
- done  out  NREQ  one-hot, high exactly one cycle (DONE state) for the granted requester.
- sum  out  SW  result; valid while done is high, held until next grant.
- ovf  out  1  sticky per operation; set if any addition carried out of SW bits; valid with done.

Behaviour:
- Reset (reset=0, async): state=IDLE, gnt=0, done=0, sum=0, ovf=0, busy=0, round-robin pointer ptr=NREQ-1, internal acc=0, k=0, nreg=0.
- States: IDLE, ACC, DONE.
- IDLE, any req bit high:
  - Winner is the first set bit searching ptr+1, ptr+2, ... modulo NREQ.
  - On that edge: gnt<=onehot(winner), nreg<=n[winner], acc<=0, ovf<=0, k<=1.
  - State<=ACC, or DONE directly if n[winner]==0.
- IDLE, no req: remain in IDLE, outputs unchanged.
- ACC, every edge:
  - acc<=acc+k, truncated to SW bits.
  - ovf<=ovf | carry-out.
  - If k==nreg: state<=DONE; otherwise k<=k+1.
  - k is NW bits wide; k never exceeds nreg, so k cannot wrap.
- DONE, for one cycle:
  - done=gnt, sum=acc (driven from acc), busy=1.
  - On the edge: gnt<=0, ptr<=winner index, state<=IDLE.
  - sum is held in a register until the next grant.
- Latency from the IDLE sampling edge to done high: n+1 cycles for n>=1; 1 cycle for n=0.
- A requester keeping req high after done is treated as a new request, but other pending requesters win first.
- Operand capture: n is sampled only at grant; changes to n during ACC/DONE are ignored.
- Dropping req mid-operation does not abort; the operation completes and done still pulses.
- A req arriving while busy waits; no grant is issued until IDLE.
- Simultaneous requests: strict round-robin from ptr. After reset, requester 0 has highest priority.
- Reset asserted mid-operation: immediate return to the reset values. No done pulse; any partial result is discarded.
- Invariants: gnt and done are always one-hot or zero; done implies busy.

Decomposition:
- Package sum_pkg holds:
  - state enum (IDLE, ACC, DONE);
  - default NREQ/NW/SW constants;
  - a function for round-robin next-index selection.
- One sub-module, sum_acc: SW-bit accumulator with clear, add-enable, addend input, carry-out and sticky overflow.
  - sum_sched contains the FSM, arbiter, k counter and nreg.
  - sum_acc contains only the datapath.

Test Plan:
- Single op: req[0]=1, n0=4 -> gnt=0001 next edge; done=0001 five cycles after sampling; sum=10, ovf=0.
- Zero operand: req[2]=1, n2=0 -> DONE on the cycle after the sampling edge; done=0100, sum=0, ovf=0.
- Overflow wrap: req[1]=1, n1=23 -> sum=20 (276 mod 256), ovf=1; next op with n1=3 gives sum=6, ovf=0.
- Arbitration: req=1111 held continuously, all n=2 -> grants in order 0,1,2,3,0; every done carries sum=3.
- Late request and operand change: req[3] rises while requester 0 is in ACC and n0 changes mid-op -> requester 0 result uses the captured n; requester 3 is granted only after done[0].
- Reset mid-op: reset=0 during ACC with n=10 -> gnt, busy, done, sum, ovf go to 0 asynchronously; no done pulse. After release, req[0] with n0=4 yields sum=10.

Source files
------------

// File: rtl/sum_pkg.sv
// Shared types, default sizes and the round-robin winner search for sum_sched.
package sum_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned NW_DEF   = 6;
    localparam int unsigned SW_DEF   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // First set request at ptr+1, ptr+2, ... modulo nreq; ptr when none is set.
    function automatic logic [2:0] rr_next(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int unsigned nreq);
        logic [2:0]  win;
        int unsigned idx;
        win = ptr;
        for (int unsigned i = 8; i > 0; i--) begin
            if (i <= nreq) begin
                idx = (32'(ptr) + i) % nreq;
                if (req[3'(idx)]) win = 3'(idx);
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/sum_acc.sv
// SW-bit wrapping accumulator with synchronous clear and a sticky carry-out flag.
module sum_acc
    import sum_pkg::*;
#(
    parameter int unsigned SW = SW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clr,
    input  logic          i_add_en,
    input  logic [SW-1:0] i_addend,
    output logic [SW-1:0] o_acc,
    output logic          o_ovf
);

    logic [SW:0]   w_sum;
    logic          w_carry;
    logic [SW-1:0] r_acc;
    logic          r_ovf;

    assign w_sum   = {1'b0, r_acc} + {1'b0, i_addend};
    assign w_carry = w_sum[SW];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_add_en) begin
            r_acc <= w_sum[SW-1:0];
            r_ovf <= r_ovf | w_carry;
        end
    end

    assign o_acc = r_acc;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/sum_sched.sv
// Round-robin scheduler sharing one sequential 1+2+..+n accumulator among NREQ requesters.
module sum_sched
    import sum_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned NW   = NW_DEF,
    parameter int unsigned SW   = SW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*NW-1:0] n,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    output logic [NREQ-1:0]    done,
    output logic [SW-1:0]      sum,
    output logic               ovf
);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt_nxt;
    logic [NREQ-1:0] r_done;
    logic            r_busy;
    logic [2:0]      r_ptr;
    logic [2:0]      r_win;
    logic [2:0]      w_win;
    logic [NW-1:0]   r_nreg;
    logic [NW-1:0]   r_k;
    logic [NW-1:0]   w_n_win;
    logic            w_any;
    logic            w_grant;
    logic            w_add_en;

    assign w_any   = |req;
    assign w_win   = rr_next(8'(req), r_ptr, NREQ);
    assign w_n_win = n[32'(w_win)*NW +: NW];

    // Next state, grant vector and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_grant     = 1'b0;
        w_add_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant     = 1'b1;
                    w_gnt_nxt   = NREQ'(1) << w_win;
                    w_state_nxt = (w_n_win == '0) ? ST_DONE : ST_ACC;
                end
            end
            ST_ACC: begin
                w_add_en = 1'b1;
                if (r_k == r_nreg) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_ptr   <= 3'(NREQ - 1);
            r_win   <= '0;
            r_nreg  <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_DONE) ? w_gnt_nxt : '0;
            if (w_grant) begin
                r_win  <= w_win;
                r_nreg <= w_n_win;
                r_k    <= NW'(1);
            end else if (w_add_en && (r_k != r_nreg)) begin
                r_k <= r_k + NW'(1);
            end
            if (r_state == ST_DONE) r_ptr <= r_win;
        end
    end

    sum_acc #(.SW(SW)) u_acc (
        .clk      (clk),
        .reset    (reset),
        .i_clr    (w_grant),
        .i_add_en (w_add_en),
        .i_addend (SW'(r_k)),
        .o_acc    (sum),
        .o_ovf    (ovf)
    );

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: tb/tb_sum_sched.sv
// Directed self-checking bench for sum_sched: vector table plus arbitration/reset sequences.
module tb_sum_sched;
    import sum_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned NW   = 6;
    localparam int unsigned SW   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*NW-1:0] n;
    logic [NREQ-1:0]    gnt;
    logic               busy;
    logic [NREQ-1:0]    done;
    logic [SW-1:0]      sum;
    logic               ovf;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        int idx;
        int nval;
        int exp_sum;
        int exp_ovf;
        int exp_lat;
    } vec_t;

    vec_t vecs[7];

    sum_sched #(.NREQ(NREQ), .NW(NW), .SW(SW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .n     (n),
        .gnt   (gnt),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        else
            n_pass++;
    endtask

    // Waits at negedges until done rises; returns cycles counted and an invariant flag.
    task automatic wait_done(output int cycles, output bit inv_ok);
        cycles = 1;
        inv_ok = 1'b1;
        while (done == '0 && cycles < 200) begin
            if (!$onehot0(gnt)) inv_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
        if (!$onehot0(done) || !busy) inv_ok = 1'b0;
    endtask

    task automatic run_op(input int idx, input int nval, input int exp_sum,
                          input int exp_ovf, input int exp_lat);
        int cycles;
        bit inv_ok;
        n[idx*NW +: NW] = NW'(nval);
        req[idx] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[idx] = 1'b0;
        chk($sformatf("gnt r%0d n%0d", idx, nval), 32'(gnt), 32'(1) << idx);
        wait_done(cycles, inv_ok);
        chk($sformatf("latency r%0d n%0d", idx, nval), 32'(cycles), 32'(exp_lat));
        chk($sformatf("done r%0d n%0d", idx, nval), 32'(done), 32'(1) << idx);
        chk($sformatf("sum r%0d n%0d", idx, nval), 32'(sum), 32'(exp_sum));
        chk($sformatf("ovf r%0d n%0d", idx, nval), 32'(ovf), 32'(exp_ovf));
        chk($sformatf("invariants r%0d n%0d", idx, nval), 32'(inv_ok), 32'd1);
        @(negedge clk);
        chk($sformatf("done pulse r%0d n%0d", idx, nval), 32'(done), 32'd0);
        chk($sformatf("idle r%0d n%0d", idx, nval), {30'd0, busy, |gnt}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int  cycles;
        bit  inv_ok;
        bit  gnt_ok;
        bit  no_done;

        vecs[0] = '{0, 4, 10, 0, 5};
        vecs[1] = '{2, 0, 0, 0, 1};
        vecs[2] = '{1, 23, 20, 1, 24};
        vecs[3] = '{1, 3, 6, 0, 4};
        vecs[4] = '{3, 63, 224, 1, 64};
        vecs[5] = '{0, 1, 1, 0, 2};
        vecs[6] = '{2, 22, 253, 0, 23};

        reset = 1'b0;
        req   = '0;
        n     = '0;
        repeat (2) @(negedge clk);
        chk("reset outputs", {gnt, done, sum, 6'd0, busy, ovf}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_op(vecs[i].idx, vecs[i].nval, vecs[i].exp_sum, vecs[i].exp_ovf, vecs[i].exp_lat);

        // All four requesting continuously from reset: strict rotation 0,1,2,3,0.
        do_reset();
        n   = {NW'(2), NW'(2), NW'(2), NW'(2)};
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wait_done(cycles, inv_ok);
            chk($sformatf("rr done #%0d", i), 32'(done), 32'(1) << (i % 4));
            chk($sformatf("rr sum #%0d", i), 32'(sum), 32'd3);
        end
        @(negedge clk);
        req = '0;
        @(negedge clk);

        // Late request from 3 plus operand change on 0 while 0 is accumulating.
        n[0*NW +: NW] = NW'(5);
        req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        n[0*NW +: NW] = NW'(9);
        @(negedge clk);
        req[3] = 1'b1;
        n[3*NW +: NW] = NW'(3);
        gnt_ok = 1'b1;
        cycles = 0;
        while (done == '0 && cycles < 200) begin
            if (gnt != 4'b0001) gnt_ok = 1'b0;
            @(negedge clk);
            cycles++;
        end
        chk("late gnt held on r0", 32'(gnt_ok), 32'd1);
        chk("late done r0", 32'(done), 32'b0001);
        chk("captured n sum r0", 32'(sum), 32'd15);
        @(negedge clk);
        chk("r3 waits until idle", 32'(gnt), 32'd0);
        @(negedge clk);
        req[3] = 1'b0;
        wait_done(cycles, inv_ok);
        chk("late done r3", 32'(done), 32'b1000);
        chk("late sum r3", 32'(sum), 32'd6);
        @(negedge clk);

        // Asynchronous reset in the middle of an accumulation.
        n[0*NW +: NW] = NW'(10);
        req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre-reset busy", 32'(busy), 32'd1);
        chk("pre-reset partial sum", 32'(sum), 32'd6);
        #1 reset = 1'b0;
        #1;
        chk("async reset gnt", 32'(gnt), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset done", 32'(done), 32'd0);
        chk("async reset sum", 32'(sum), 32'd0);
        chk("async reset ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        no_done = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done != '0 || busy) no_done = 1'b0;
        end
        chk("no done after reset", 32'(no_done), 32'd1);
        run_op(0, 4, 10, 0, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
